// File: rtl/multitap_keypad_encoder.sv
// Matrix keypad scanner/debouncer with phone-style multi-tap letter entry.
// Latency: key_event one cycle after debounce completes; letter/word outputs one cycle after key_event.
// Backpressure: none; pulses are fire-and-forget. Build option MULTITAP_AUTOCOMMIT_EN commits on tap timeout.
module multitap_keypad_encoder #(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SCAN_DWELL      = 1000,
    parameter int DEBOUNCE_CYCLES = 2000,
    parameter int TAP_TIMEOUT     = 50000
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic [ROWS-1:0]               row_in,
    output logic [COLS-1:0]               col_out,
    output logic                          key_event,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          pending_valid,
    output logic [7:0]                    pending_letter,
    output logic                          letter_valid,
    output logic [7:0]                    letter,
    output logic                          word_submit
);
    localparam int KW   = $clog2(ROWS*COLS);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CMAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TAP_TIMEOUT + 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d, col_next;
    logic [ROWS-1:0] cand_row_q, cand_row_d;
    logic [KW-1:0]   cand_code_q, cand_code_d, hit_code;
    logic [RW-1:0]   hit_row;
    logic            key_event_q, key_event_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic [KW-1:0]   pend_key_q, pend_key_d;
    logic [1:0]      tap_idx_q, tap_idx_d;
    logic [TW-1:0]   tap_timer_q, tap_timer_d;
    logic            pending_valid_q, pending_valid_d;
    logic [7:0]      pending_letter_q, pending_letter_d;
    logic            letter_valid_q, letter_valid_d;
    logic [7:0]      letter_q, letter_d;
    logic            word_submit_q, word_submit_d;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q          <= SCAN;
            cnt_q            <= '0;
            col_q            <= '0;
            cand_row_q       <= '0;
            cand_code_q      <= '0;
            key_event_q      <= 1'b0;
            key_code_q       <= '0;
            pend_key_q       <= '0;
            tap_idx_q        <= '0;
            tap_timer_q      <= '0;
            pending_valid_q  <= 1'b0;
            pending_letter_q <= '0;
            letter_valid_q   <= 1'b0;
            letter_q         <= '0;
            word_submit_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            col_q            <= col_d;
            cand_row_q       <= cand_row_d;
            cand_code_q      <= cand_code_d;
            key_event_q      <= key_event_d;
            key_code_q       <= key_code_d;
            pend_key_q       <= pend_key_d;
            tap_idx_q        <= tap_idx_d;
            tap_timer_q      <= tap_timer_d;
            pending_valid_q  <= pending_valid_d;
            pending_letter_q <= pending_letter_d;
            letter_valid_q   <= letter_valid_d;
            letter_q         <= letter_d;
            word_submit_q    <= word_submit_d;
        end
    end

    always_comb begin
        hit_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_in[r]) hit_row = RW'(r);
        end
        hit_code = KW'(int'(hit_row) * COLS + int'(col_q));
        col_next = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end

    // Scan / debounce FSM: the column drive stays frozen from candidate latch until release completes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        cand_code_d = cand_code_q;
        key_event_d = 1'b0;
        key_code_d  = key_code_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == CNTW'(SCAN_DWELL - 1)) begin
                    cnt_d = '0;
                    if ($onehot(row_in)) begin
                        state_d     = DEB_PRESS;
                        cand_row_d  = row_in;
                        cand_code_d = hit_code;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (row_in == cand_row_q) begin
                    if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d     = HELD;
                        cnt_d       = '0;
                        key_event_d = 1'b1;
                        key_code_d  = cand_code_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = col_next;
                end
            end
            HELD: begin
                if (row_in == '0) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (row_in != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = col_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Multi-tap: the _d values double as working state so a timeout commit precedes a same-cycle press.
    always_comb begin
        pend_key_d       = pend_key_q;
        tap_idx_d        = tap_idx_q;
        pending_valid_d  = pending_valid_q;
        pending_letter_d = pending_letter_q;
        letter_valid_d   = 1'b0;
        letter_d         = letter_q;
        word_submit_d    = 1'b0;
        if (!pending_valid_q)
            tap_timer_d = '0;
        else if (tap_timer_q == TW'(TAP_TIMEOUT))
            tap_timer_d = tap_timer_q;
        else
            tap_timer_d = tap_timer_q + 1'b1;
`ifdef MULTITAP_AUTOCOMMIT_EN
        if (pending_valid_q && tap_timer_q == TW'(TAP_TIMEOUT)) begin
            letter_valid_d   = 1'b1;
            letter_d         = pending_letter_q;
            pending_valid_d  = 1'b0;
            pending_letter_d = '0;
            tap_timer_d      = '0;
        end
`endif
        if (key_event_q) begin
            if (int'(key_code_q) <= 8) begin
                if (pending_valid_d && key_code_q == pend_key_q &&
                    tap_timer_q < TW'(TAP_TIMEOUT)) begin
                    tap_idx_d = (tap_idx_q == ((int'(key_code_q) == 8) ? 2'd1 : 2'd2)) ?
                                2'd0 : tap_idx_q + 2'd1;
                end else begin
                    tap_idx_d  = 2'd0;
                    pend_key_d = key_code_q;
                end
                pending_valid_d  = 1'b1;
                pending_letter_d = 8'(65 + 3 * int'(key_code_q) + int'(tap_idx_d));
                tap_timer_d      = '0;
            end else if (int'(key_code_q) == 9) begin
                pending_valid_d  = 1'b0;
                pending_letter_d = '0;
            end else if (int'(key_code_q) == 10) begin
                if (pending_valid_d) begin
                    letter_valid_d   = 1'b1;
                    letter_d         = pending_letter_d;
                    pending_valid_d  = 1'b0;
                    pending_letter_d = '0;
                end
            end else if (int'(key_code_q) == 11) begin
                word_submit_d = 1'b1;
            end
        end
    end

    always_comb begin
        col_out        = COLS'(1) << col_q;
        key_event      = key_event_q;
        key_code       = key_code_q;
        pending_valid  = pending_valid_q;
        pending_letter = pending_letter_q;
        letter_valid   = letter_valid_q;
        letter         = letter_q;
        word_submit    = word_submit_q;
    end
endmodule

// File: tb/tb_multitap_keypad_encoder.sv
// Directed bench for multitap_keypad_encoder with a behavioural key matrix driven from col_out.
module tb_multitap_keypad_encoder;
    localparam int ROWS = 4;
    localparam int COLS = 3;

    logic        clk = 1'b0;
    logic        nRst;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic        key_event;
    logic [3:0]  key_code;
    logic        pending_valid;
    logic [7:0]  pending_letter;
    logic        letter_valid;
    logic [7:0]  letter;
    logic        word_submit;
    logic [11:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int lv_cnt   = 0;
    int ws_cnt   = 0;
    int ke_cnt   = 0;
    logic [7:0] last_letter = '0;

    multitap_keypad_encoder #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8), .TAP_TIMEOUT(100)
    ) dut (
        .clk(clk), .nRst(nRst), .row_in(row_in), .col_out(col_out),
        .key_event(key_event), .key_code(key_code),
        .pending_valid(pending_valid), .pending_letter(pending_letter),
        .letter_valid(letter_valid), .letter(letter), .word_submit(word_submit)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys[r*COLS+c] && col_out[c]) row_in[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (nRst) begin
            if (key_event) ke_cnt++;
            if (word_submit) ws_cnt++;
            if (letter_valid) begin
                lv_cnt++;
                last_letter = letter;
            end
        end
    end

    task automatic press_start(input int code, output bit seen);
        keys = 12'(1) << code;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (key_event) seen = 1'b1;
        end
    endtask

    task automatic release_key();
        keys = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (col_out !== 3'b001) begin n_fail++; $display("FAIL reset_col: got %b want 001", col_out); end
        n_checks++; if (key_event !== 1'b0) begin n_fail++; $display("FAIL reset_key_event: got %b want 0", key_event); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
        n_checks++; if (pending_valid !== 1'b0 || pending_letter !== 8'h00) begin
            n_fail++; $display("FAIL reset_pending: got %b/%h want 0/00", pending_valid, pending_letter); end
        n_checks++; if (letter_valid !== 1'b0 || letter !== 8'h00 || word_submit !== 1'b0) begin
            n_fail++; $display("FAIL reset_letter: got %b/%h/%b want 0/00/0", letter_valid, letter, word_submit); end
        nRst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_letter();
        bit seen;
        int base;
        press_start(0, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_press_seen: got %b want 1", seen); end
        @(negedge clk);
        n_checks++; if (pending_valid !== 1'b1 || pending_letter !== 8'h41) begin
            n_fail++; $display("FAIL single_pending: got %b/%h want 1/41", pending_valid, pending_letter); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL single_key_code: got %0d want 0", key_code); end
        release_key();
        base = lv_cnt;
        press_start(10, seen);
        @(negedge clk);
        n_checks++; if (letter_valid !== 1'b1 || letter !== 8'h41) begin
            n_fail++; $display("FAIL submit_letter: got %b/%h want 1/41", letter_valid, letter); end
        release_key();
        n_checks++; if (lv_cnt - base !== 1) begin n_fail++; $display("FAIL submit_pulses: got %0d want 1", lv_cnt - base); end
        n_checks++; if (pending_valid !== 1'b0) begin n_fail++; $display("FAIL submit_clears: got %b want 0", pending_valid); end
    endtask

    task automatic test_multi_tap();
        bit seen;
        logic [7:0] exp_l [3];
        exp_l[0] = 8'h4A; exp_l[1] = 8'h4B; exp_l[2] = 8'h4C;
        for (int i = 0; i < 3; i++) begin
            press_start(3, seen);
            @(negedge clk);
            n_checks++; if (pending_letter !== exp_l[i] || key_code !== 4'd3) begin
                n_fail++; $display("FAIL tap3_%0d: got %h code %0d want %h code 3", i, pending_letter, key_code, exp_l[i]); end
            release_key();
        end
        press_start(10, seen);
        release_key();
        n_checks++; if (letter !== 8'h4C) begin n_fail++; $display("FAIL tap3_commit: got %h want 4c", letter); end
    endtask

    task automatic test_wrap();
        bit seen;
        logic [7:0] exp_l [3];
        exp_l[0] = 8'h59; exp_l[1] = 8'h5A; exp_l[2] = 8'h59;
        for (int i = 0; i < 3; i++) begin
            press_start(8, seen);
            @(negedge clk);
            n_checks++; if (pending_letter !== exp_l[i]) begin
                n_fail++; $display("FAIL wrap8_%0d: got %h want %h", i, pending_letter, exp_l[i]); end
            release_key();
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int base;
        press_start(4, seen);
        @(negedge clk);
        n_checks++; if (pending_letter !== 8'h4D) begin n_fail++; $display("FAIL timeout_first: got %h want 4d", pending_letter); end
        base = lv_cnt;
        keys = '0;
        repeat (150) @(negedge clk);
`ifdef MULTITAP_AUTOCOMMIT_EN
        n_checks++; if (lv_cnt - base !== 1 || last_letter !== 8'h4D) begin
            n_fail++; $display("FAIL autocommit: got %0d pulses letter %h want 1 pulse 4d", lv_cnt - base, last_letter); end
        n_checks++; if (pending_valid !== 1'b0) begin n_fail++; $display("FAIL autocommit_clear: got %b want 0", pending_valid); end
`else
        n_checks++; if (lv_cnt - base !== 0) begin n_fail++; $display("FAIL timeout_no_commit: got %0d pulses want 0", lv_cnt - base); end
        n_checks++; if (pending_valid !== 1'b1 || pending_letter !== 8'h4D) begin
            n_fail++; $display("FAIL timeout_hold: got %b/%h want 1/4d", pending_valid, pending_letter); end
`endif
        press_start(4, seen);
        @(negedge clk);
        n_checks++; if (pending_letter !== 8'h4D) begin n_fail++; $display("FAIL timeout_restart: got %h want 4d", pending_letter); end
        release_key();
    endtask

    task automatic test_bounce();
        bit seen;
        int base;
        for (int i = 0; i < 200 && col_out !== 3'b001; i++) @(negedge clk);
        base = ke_cnt;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 12'(1) << 3 : '0;
            @(negedge clk);
        end
        n_checks++; if (ke_cnt - base !== 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d events want 0", ke_cnt - base); end
        press_start(3, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bounce_stable: got %b want 1", seen); end
        repeat (40) @(negedge clk);
        n_checks++; if (ke_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_once: got %0d events want 1", ke_cnt - base); end
        release_key();
    endtask

    task automatic test_two_rows();
        int base;
        base = ke_cnt;
        keys = 12'b0000_0000_1001;
        repeat (60) @(negedge clk);
        n_checks++; if (ke_cnt - base !== 0) begin n_fail++; $display("FAIL two_rows: got %0d events want 0", ke_cnt - base); end
        release_key();
    endtask

    task automatic test_word_submit();
        bit seen;
        int base;
        base = ws_cnt;
        press_start(11, seen);
        release_key();
        n_checks++; if (ws_cnt - base !== 1) begin n_fail++; $display("FAIL word_submit: got %0d pulses want 1", ws_cnt - base); end
`ifdef MULTITAP_AUTOCOMMIT_EN
        n_checks++; if (pending_letter !== 8'h00) begin n_fail++; $display("FAIL word_pending: got %h want 00", pending_letter); end
`else
        n_checks++; if (pending_letter !== 8'h4A) begin n_fail++; $display("FAIL word_pending: got %h want 4a", pending_letter); end
`endif
    endtask

    task automatic test_clear();
        bit seen;
        int base;
        press_start(5, seen);
        release_key();
        n_checks++; if (pending_letter !== 8'h50) begin n_fail++; $display("FAIL clear_setup: got %h want 50", pending_letter); end
        press_start(9, seen);
        release_key();
        n_checks++; if (pending_valid !== 1'b0 || pending_letter !== 8'h00) begin
            n_fail++; $display("FAIL clear: got %b/%h want 0/00", pending_valid, pending_letter); end
        base = lv_cnt;
        press_start(10, seen);
        release_key();
        n_checks++; if (lv_cnt - base !== 0) begin n_fail++; $display("FAIL clear_submit: got %0d pulses want 0", lv_cnt - base); end
    endtask

    task automatic test_reset_mid_held();
        bit seen;
        int base;
        press_start(1, seen);
        repeat (3) @(negedge clk);
        base = ke_cnt;
        #2 nRst = 1'b0;
        #1;
        n_checks++; if (col_out !== 3'b001) begin n_fail++; $display("FAIL held_reset_col: got %b want 001", col_out); end
        n_checks++; if (pending_valid !== 1'b0 || letter_valid !== 1'b0 || key_event !== 1'b0) begin
            n_fail++; $display("FAIL held_reset_outs: got %b/%b/%b want 0/0/0", pending_valid, letter_valid, key_event); end
        keys = '0;
        @(negedge clk);
        nRst = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++; if (ke_cnt - base !== 0 || pending_valid !== 1'b0) begin
            n_fail++; $display("FAIL held_reset_quiet: got %0d events pv %b want 0/0", ke_cnt - base, pending_valid); end
    endtask

    initial begin
        nRst = 1'b0;
        test_reset();
        test_single_letter();
        test_multi_tap();
        test_wrap();
        test_timeout();
        test_bounce();
        test_two_rows();
        test_word_submit();
        test_clear();
        test_reset_mid_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multitap_keypad_encoder.md
Name: multitap_keypad_encoder

Overview:
- Parametrised keypad front end for the hangman host and player consoles.
- Scans a ROWS x COLS matrix one column at a time and debounces presses and releases.
- Converts repeated taps of a key into letters, phone-style multi-tap (A/B/C on one key).
- Emits committed letters and word-submit strobes to the game controller; replaces per-role ad-hoc row decoding.

Parameters:
- ROWS, 4, number of row inputs.
- COLS, 3, number of column drive outputs; ROWS*COLS must be >= 12.
- SCAN_DWELL, 1000, cycles each column is driven before its rows are sampled.
- DEBOUNCE_CYCLES, 2000, consecutive stable cycles required to accept a press or a release.
- TAP_TIMEOUT, 50000, cycles after a press within which the same key advances the tap.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- row_in  in  ROWS  active-high row sense; bit r is row r
- col_out  out  COLS  one-hot column drive
- key_event  out  1  one-cycle pulse per debounced press
- key_code  out  $clog2(ROWS*COLS)  code of last press = r*COLS + c; held until next press
- pending_valid  out  1  a multi-tap candidate letter is held
- pending_letter  out  8  ASCII of the candidate letter; 0 when pending_valid=0
- letter_valid  out  1  one-cycle pulse; a letter is committed
- letter  out  8  committed ASCII; held until next commit
- word_submit  out  1  one-cycle pulse on word-submit key

Behaviour:
- Reset (async, nRst=0): col_out=1 (column 0), FSM=SCAN, all counters 0, every other output 0.
- Key map, codes 0-8 (letter keys):
  - Code k owns letters 'A'+3k .. 'A'+3k+2, clipped at 'Z'.
  - Group sizes: code 8 has 2 letters (Y,Z); all others have 3.
- Key map, control and unused codes:
  - 9 = clear: drop the pending letter.
  - 10 = submit letter.
  - 11 = submit word.
  - Codes >= 12: key_event fires; no other effect.
- FSM state SCAN:
  - Drive col c for SCAN_DWELL cycles, then sample row_in.
  - Exactly one row bit set: latch candidate (r,c), go to DEB_PRESS; column drive frozen.
  - Zero bits or more than one bit set: advance c (wraps COLS-1 -> 0) and restart dwell.
- FSM state DEB_PRESS:
  - row_in must equal the candidate pattern for DEBOUNCE_CYCLES consecutive cycles.
  - On success: go to HELD; key_event=1 for exactly the following cycle; key_code updated that same cycle.
  - On any mismatch: return to SCAN and advance the column.
- FSM state HELD: wait for row_in==0, then go to DEB_RELEASE. There is no auto-repeat.
- FSM state DEB_RELEASE:
  - row_in must be 0 for DEBOUNCE_CYCLES cycles; then go to SCAN and advance the column.
  - Any nonzero sample restarts the count while staying in DEB_RELEASE.
- Key processing, in the cycle key_event is high:
  - Letter key, same as the pending key and tap timer < TAP_TIMEOUT: tap index advances, wrapping past the group size back to the first letter.
  - Letter key, otherwise: pending becomes the first letter of the new group with tap index 0. The old pending letter is discarded, not committed.
  - Every letter press: tap timer restarts at 0.
  - Clear: pending_valid=0, pending_letter=0.
  - Submit letter with pending_valid=1: letter=pending_letter, letter_valid pulse, pending cleared.
  - Submit letter with pending_valid=0: no pulse.
  - Submit word: word_submit pulse; pending unchanged.
- Tap timer: counts while pending_valid=1 and saturates at TAP_TIMEOUT. At saturation the pending letter stays displayed, but the next press of the same key restarts at its first letter.
- Latency: pending_letter and the letter/word pulses update in the cycle after key_event.
- A reset in any state returns to SCAN at column 0 immediately; no pulse is emitted.

Optional Feature:
- Macro: MULTITAP_AUTOCOMMIT_EN.
- Defined: when the tap timer reaches TAP_TIMEOUT with pending_valid=1, the pending letter is committed exactly as by submit letter (letter_valid pulse, pending cleared). A letter press landing on the commit cycle itself starts a fresh pending letter after the commit.
- Undefined: timeout only ends the tap sequence; commit happens only via submit letter.

Test Plan (SCAN_DWELL=4, DEBOUNCE_CYCLES=8, TAP_TIMEOUT=100):
- Reset mid-HELD -> col_out=3'b001; pending_valid=0, letter_valid=0, key_event=0 within the reset cycle.
- Code 0 once, then code 10 -> pending_letter 'A' (0x41); letter_valid pulse with letter=0x41; pending_valid=0.
- Code 3 tapped 3x within timeout, then code 10 -> pending steps 'J','K','L'; letter=0x4C.
- Code 8 tapped 3x -> 'Y','Z','Y' (wrap). Code 4 tapped twice with 150 idle cycles between -> 'M' then 'M' again; with the macro defined, letter_valid=0x4D fires at the timeout.
- 5-cycle bounce on row 1 before a stable press -> no key_event during bounce; exactly one key_event after stability.
- Two rows asserted in one column -> no key_event.
- Code 11 -> single word_submit pulse.
- Code 9 after 'P' -> pending_valid=0; a following code 10 gives no letter_valid.
